// File: rtl/fir_poly_mac_flex.sv
// Time-shared polyphase FIR: NUM_MAC multipliers sweep NUM_TAPS taps over C clocks,
// followed by a rounding/saturation stage and a one-clock output-valid strobe.
module fir_poly_mac_flex #(
  parameter int NUM_TAPS = 33,
  parameter int NUM_MAC  = 4,
  parameter int COEF_W   = 16,
  parameter int IN_W     = 3,
  parameter int ADDR_W   = 6,
  parameter int ACC_W    = 25,
  parameter int OUT_W    = 16,
  parameter int SHIFT    = 0
) (
  input  logic                     iClk12M,
  input  logic                     iRsn,
  input  logic                     iEnSample,
  input  logic                     iCoeffUpdateFlag,
  input  logic                     iCsnRam,
  input  logic                     iWrnRam,
  input  logic [ADDR_W-1:0]        iAddrRam,
  input  logic signed [COEF_W-1:0] iWrDtRam,
  output logic signed [COEF_W-1:0] oRdDtRam,
  input  logic signed [IN_W-1:0]   iFirIn,
  output logic signed [OUT_W-1:0]  oFirOut,
  output logic                     oFirValid,
  output logic                     oBusy,
  output logic                     oOverrun,
  output logic [1:0]               oDbgState
);

  localparam int NUM_CYC = (NUM_TAPS + NUM_MAC - 1) / NUM_MAC;
  localparam int CYC_W   = (NUM_CYC > 1) ? $clog2(NUM_CYC) : 1;
  localparam logic [ADDR_W:0] TAPS_LIM = (ADDR_W+1)'(NUM_TAPS);
  localparam logic signed [ACC_W:0] HALF    = (ACC_W+1)'((64'd1 << SHIFT) >> 1);
  localparam logic signed [ACC_W:0] SAT_MAX = (ACC_W+1)'((64'sd1 <<< (OUT_W-1)) - 64'sd1);
  localparam logic signed [ACC_W:0] SAT_MIN = (ACC_W+1)'(-(64'sd1 <<< (OUT_W-1)));
  localparam logic signed [OUT_W-1:0] OUT_MAX = {1'b0, {(OUT_W-1){1'b1}}};
  localparam logic signed [OUT_W-1:0] OUT_MIN = {1'b1, {(OUT_W-1){1'b0}}};

  typedef enum logic [1:0] {S_IDLE, S_MAC, S_ROUND, S_DONE} state_t;

  state_t                     r_state;
  state_t                     w_state_nxt;
  logic [CYC_W-1:0]           r_cyc;
  logic signed [COEF_W-1:0]   r_coef [NUM_TAPS];
  logic signed [IN_W-1:0]     r_tap  [NUM_TAPS];
  logic signed [ACC_W-1:0]    r_acc;
  logic signed [OUT_W-1:0]    r_round;
  logic signed [ACC_W-1:0]    w_lane_sum;
  logic signed [COEF_W+IN_W-1:0] w_prod;
  logic signed [ACC_W:0]      w_biased;
  logic signed [ACC_W:0]      w_shr;
  logic signed [OUT_W-1:0]    w_sat;
  logic                       w_accept;
  logic                       w_last_cyc;
  logic                       w_addr_ok;
  logic                       w_wr_en;
  int                         w_idx;

  // valid/ready: a sample is taken only on an iEnSample clock while IDLE and not in
  // update mode; oFirValid marks the single clock on which oFirOut carries a new result.
  assign w_accept   = iEnSample && !iCoeffUpdateFlag && (r_state == S_IDLE);
  assign w_last_cyc = (r_cyc == CYC_W'(NUM_CYC - 1));
  assign w_addr_ok  = ({1'b0, iAddrRam} < TAPS_LIM);
  assign w_wr_en    = iCoeffUpdateFlag && !iCsnRam && !iWrnRam && w_addr_ok && (r_state == S_IDLE);
  assign oBusy      = (r_state != S_IDLE);
  assign oDbgState  = r_state;

  always_comb begin
    w_state_nxt = r_state;
    case (r_state)
      S_IDLE:  if (w_accept) w_state_nxt = S_MAC;
      S_MAC:   if (w_last_cyc) w_state_nxt = S_ROUND;
      S_ROUND: w_state_nxt = S_DONE;
      S_DONE:  w_state_nxt = S_IDLE;
      default: w_state_nxt = S_IDLE;
    endcase
  end

  // Lanes past the last tap on the final cycle contribute nothing.
  always_comb begin
    w_lane_sum = '0;
    w_prod     = '0;
    w_idx      = 0;
    for (int l = 0; l < NUM_MAC; l++) begin
      w_idx = int'(r_cyc) * NUM_MAC + l;
      if (w_idx < NUM_TAPS) begin
        w_prod     = r_coef[w_idx[ADDR_W-1:0]] * r_tap[w_idx[ADDR_W-1:0]];
        w_lane_sum = w_lane_sum + ACC_W'(w_prod);
      end
    end
  end

  always_comb begin
    w_biased = {r_acc[ACC_W-1], r_acc} + HALF;
    w_shr    = w_biased >>> SHIFT;
    if (w_shr > SAT_MAX)      w_sat = OUT_MAX;
    else if (w_shr < SAT_MIN) w_sat = OUT_MIN;
    else                      w_sat = w_shr[OUT_W-1:0];
  end

  always_ff @(posedge iClk12M or negedge iRsn) begin
    if (!iRsn) begin
      r_state   <= S_IDLE;
      r_cyc     <= '0;
      r_acc     <= '0;
      r_round   <= '0;
      oFirOut   <= '0;
      oFirValid <= 1'b0;
      oOverrun  <= 1'b0;
      oRdDtRam  <= '0;
      for (int k = 0; k < NUM_TAPS; k++) begin
        r_coef[k] <= '0;
        r_tap[k]  <= '0;
      end
    end else begin
      r_state   <= w_state_nxt;
      oFirValid <= 1'b0;
      if (iEnSample && (r_state != S_IDLE)) oOverrun <= 1'b1;
      case (r_state)
        S_IDLE: begin
          if (w_accept) begin
            r_tap[0] <= iFirIn;
            for (int k = 1; k < NUM_TAPS; k++) r_tap[k] <= r_tap[k-1];
            r_acc <= '0;
            r_cyc <= '0;
          end
        end
        S_MAC: begin
          r_acc <= r_acc + w_lane_sum;
          r_cyc <= r_cyc + 1'b1;
        end
        S_ROUND: r_round <= w_sat;
        S_DONE: begin
          oFirOut   <= r_round;
          oFirValid <= 1'b1;
        end
        default: ;
      endcase
      if (w_wr_en) r_coef[iAddrRam] <= iWrDtRam;
      if (!iCsnRam && iWrnRam) oRdDtRam <= w_addr_ok ? r_coef[iAddrRam] : '0;
    end
  end

endmodule

// File: tb/tb_fir_poly_mac_flex.sv
// Directed bench for fir_poly_mac_flex: reset, coefficient RAM, impulse response,
// saturation, overrun and reset during MAC.
module tb_fir_poly_mac_flex;

  logic               clk = 1'b0;
  logic               rst_n = 1'b0;
  logic               en_sample = 1'b0;
  logic               upd_flag = 1'b0;
  logic               csn = 1'b1;
  logic               wrn = 1'b1;
  logic [5:0]         addr = '0;
  logic signed [15:0] wr_dt = '0;
  logic signed [15:0] rd_dt;
  logic signed [2:0]  fir_in = '0;
  logic signed [15:0] fir_out;
  logic               fir_valid;
  logic               busy;
  logic               overrun;
  logic [1:0]         dbg_state;

  int n_total = 0;
  int n_pass  = 0;
  int n_fail  = 0;

  fir_poly_mac_flex dut (
    .iClk12M          (clk),
    .iRsn             (rst_n),
    .iEnSample        (en_sample),
    .iCoeffUpdateFlag (upd_flag),
    .iCsnRam          (csn),
    .iWrnRam          (wrn),
    .iAddrRam         (addr),
    .iWrDtRam         (wr_dt),
    .oRdDtRam         (rd_dt),
    .iFirIn           (fir_in),
    .oFirOut          (fir_out),
    .oFirValid        (fir_valid),
    .oBusy            (busy),
    .oOverrun         (overrun),
    .oDbgState        (dbg_state)
  );

  // clock / reset
  always #5 clk = ~clk;

  initial begin
    #2_000_000;
    $display("FAIL watchdog: observed=timeout expected=finish");
    $fatal(1, "watchdog expired");
  end

  function automatic int h_of(input int k);
    case (k)
      0:       return 146;
      2:       return -242;
      16:      return 21845;
      32:      return 146;
      default: return k * 37 - 500;
    endcase
  endfunction

  task automatic check(input string tag, input logic signed [31:0] obs, input logic signed [31:0] exp);
    n_total++;
    assert (obs === exp) n_pass++;
    else begin
      n_fail++;
      $error("FAIL %s: observed=%0d expected=%0d", tag, obs, exp);
    end
  endtask

  // driver tasks
  task automatic do_reset();
    @(negedge clk);
    rst_n = 1'b0;
    repeat (5) @(negedge clk);
    rst_n = 1'b1;
    @(negedge clk);
  endtask

  task automatic ram_write(input int a, input int d);
    @(negedge clk);
    upd_flag = 1'b1;
    csn = 1'b0;
    wrn = 1'b0;
    addr = 6'(a);
    wr_dt = 16'(d);
    @(negedge clk);
    csn = 1'b1;
    wrn = 1'b1;
  endtask

  task automatic ram_read(input int a, output logic signed [15:0] val);
    @(negedge clk);
    csn = 1'b0;
    wrn = 1'b1;
    addr = 6'(a);
    @(negedge clk);
    val = rd_dt;
    csn = 1'b1;
  endtask

  task automatic load_table();
    for (int k = 0; k < 33; k++) ram_write(k, h_of(k));
    upd_flag = 1'b0;
  endtask

  task automatic wait_valid(output int lat, output logic signed [15:0] y);
    bit found = 1'b0;
    lat = 0;
    for (int i = 0; i < 30; i++) begin
      @(negedge clk);
      lat++;
      if (fir_valid) begin
        found = 1'b1;
        break;
      end
    end
    if (!found) lat = -1;
    y = fir_out;
  endtask

  // one strobe at a 20-clock period; returns latency, output and valid one clock later
  task automatic sample(input logic signed [2:0] x, output int lat,
                        output logic signed [15:0] y, output logic v_after);
    @(negedge clk);
    en_sample = 1'b1;
    fir_in = x;
    @(negedge clk);
    en_sample = 1'b0;
    wait_valid(lat, y);
    @(negedge clk);
    v_after = fir_valid;
    repeat (6) @(negedge clk);
  endtask

  initial begin
    int                 lat;
    logic signed [15:0] y;
    logic signed [15:0] rv;
    logic               va;
    int                 pulses;

    // 1. reset
    repeat (5) @(negedge clk);
    check("rst_out", fir_out, 0);
    check("rst_valid", fir_valid, 0);
    check("rst_busy", busy, 0);
    check("rst_overrun", overrun, 0);
    check("rst_rddt", rd_dt, 0);
    rst_n = 1'b1;
    @(negedge clk);

    // 2. write / readback
    load_table();
    ram_read(16, rv);
    check("rd_h16", rv, 21845);
    ram_read(2, rv);
    check("rd_h2", rv, -242);
    ram_write(40, 1234);
    upd_flag = 1'b0;
    ram_read(40, rv);
    check("rd_oob40", rv, 0);

    // strobe in update mode is ignored without overrun
    @(negedge clk);
    upd_flag = 1'b1;
    en_sample = 1'b1;
    fir_in = 3'sb001;
    @(negedge clk);
    en_sample = 1'b0;
    upd_flag = 1'b0;
    check("upd_strobe_busy", busy, 0);
    check("upd_strobe_ovr", overrun, 0);

    // 3. impulse response
    for (int k = 0; k < 34; k++) begin
      sample((k == 0) ? 3'sb001 : 3'sb000, lat, y, va);
      check($sformatf("imp_y%0d", k), y, (k < 33) ? h_of(k) : 0);
      if (k < 3) begin
        check($sformatf("imp_lat%0d", k), lat, 11);
        check($sformatf("imp_vdrop%0d", k), va, 0);
      end
    end

    // 4. saturation
    for (int k = 0; k < 33; k++) ram_write(k, 21845);
    upd_flag = 1'b0;
    for (int k = 0; k < 33; k++) begin
      sample(3'sb011, lat, y, va);
      if (k == 0) check("sat_pos_first", y, 32767);
    end
    check("sat_pos", y, 32767);
    for (int k = 0; k < 33; k++) sample(3'sb101, lat, y, va);
    check("sat_neg", y, -32768);
    check("sat_no_ovr", overrun, 0);

    // 5. overrun; also a write attempted while busy must be blocked
    do_reset();
    load_table();
    @(negedge clk);
    en_sample = 1'b1;
    fir_in = 3'sb001;
    @(negedge clk);
    en_sample = 1'b0;
    repeat (4) @(negedge clk);
    en_sample = 1'b1;
    fir_in = 3'sb011;
    @(negedge clk);
    en_sample = 1'b0;
    check("ovr_flag", overrun, 1);
    upd_flag = 1'b1;
    csn = 1'b0;
    wrn = 1'b0;
    addr = 6'd5;
    wr_dt = 16'sd999;
    @(negedge clk);
    csn = 1'b1;
    wrn = 1'b1;
    upd_flag = 1'b0;
    wait_valid(lat, y);
    check("ovr_y0", y, h_of(0));
    repeat (8) @(negedge clk);
    sample(3'sb000, lat, y, va);
    check("ovr_y1", y, h_of(1));
    sample(3'sb000, lat, y, va);
    check("ovr_y2", y, h_of(2));
    check("ovr_sticky", overrun, 1);
    ram_read(5, rv);
    check("busy_wr_blocked", rv, h_of(5));

    // 6. reset mid-MAC
    @(negedge clk);
    en_sample = 1'b1;
    fir_in = 3'sb001;
    @(negedge clk);
    en_sample = 1'b0;
    check("mid_busy", busy, 1);
    repeat (3) @(posedge clk);
    #1 rst_n = 1'b0;
    #1 check("mid_rst_busy", busy, 0);
    check("mid_rst_ovr", overrun, 0);
    repeat (2) @(negedge clk);
    rst_n = 1'b1;
    pulses = 0;
    for (int i = 0; i < 15; i++) begin
      @(negedge clk);
      if (fir_valid) pulses++;
    end
    check("mid_no_valid", pulses, 0);
    ram_read(16, rv);
    check("mid_coef16", rv, 0);
    ram_read(0, rv);
    check("mid_coef0", rv, 0);

    $display("%0d/%0d checks passed", n_pass, n_total);
    $finish;
  end

endmodule
